// File: rtl/elevator_scan_ctrl_if.sv
// rtl/elevator_scan_ctrl_if.sv - floor-call request channel between call logic and the car controller
// The controller answers a call on the same channel with an out-of-range error pulse.
interface elevator_scan_ctrl_if #(
    parameter int FLOOR_W = 4
) ();
    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic               req_err;

    modport master (
        output req_valid,
        output req_floor,
        input  req_err
    );

    modport slave (
        input  req_valid,
        input  req_floor,
        output req_err
    );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - SCAN-order elevator controller with per-floor travel and door dwell timing
// Calls are latched into a pending bitmap; the car keeps direction while calls remain ahead.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS  = 10,
    parameter int FLOOR_W     = 4,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    elevator_scan_ctrl_if.slave   req,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  moving,
    output logic                  direction,
    output logic                  door_open,
    output logic                  arrived,
    output logic [NUM_FLOORS-1:0] pending
);
    localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]   MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W:0]   FLOOR_LIM = (FLOOR_W + 1)'(NUM_FLOORS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;

    logic                req_in_range;
    logic                req_here;
    logic                req_latch;
    logic [FLOOR_W-1:0]  step_floor;
    logic [NUM_FLOORS-1:0] req_bit;
    logic [NUM_FLOORS-1:0] above_mask;
    logic [NUM_FLOORS-1:0] below_mask;
    logic [NUM_FLOORS-1:0] step_bit;
    logic [NUM_FLOORS-1:0] pend_req;
    logic                step_hit;
    logic                call_ahead;
    logic                call_behind;

    assign moving    = (state == MOVE);
    assign door_open = (state == DOOR);

    always_comb begin
        req_in_range = req.req_valid && ({1'b0, req.req_floor} < FLOOR_LIM);
        // A call for the floor the car is standing at reopens/holds the door instead of latching.
        req_here     = req_in_range && (req.req_floor == current_floor) && (state != MOVE);
        req_latch    = req_in_range && !req_here;
        step_floor   = direction ? (current_floor + 1'b1) : (current_floor - 1'b1);
        req_bit      = '0;
        above_mask   = '0;
        below_mask   = '0;
        step_bit     = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            req_bit[i]    = req_latch && (req.req_floor == FLOOR_W'(i));
            above_mask[i] = (FLOOR_W'(i) > current_floor);
            below_mask[i] = (FLOOR_W'(i) < current_floor);
            step_bit[i]   = (step_floor == FLOOR_W'(i));
        end
        pend_req    = pending | req_bit;
        step_hit    = |(pend_req & step_bit);
        call_ahead  = direction ? |(pending & above_mask) : |(pending & below_mask);
        call_behind = direction ? |(pending & below_mask) : |(pending & above_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            current_floor <= '0;
            direction     <= 1'b1;
            pending       <= '0;
            arrived       <= 1'b0;
            req.req_err   <= 1'b0;
        end else begin
            req.req_err <= req.req_valid && !req_in_range;
            arrived     <= 1'b0;
            pending     <= pend_req;
            case (state)
                IDLE: begin
                    if (req_here) begin
                        state <= DOOR;
                        cnt   <= '0;
                    end else if (call_ahead || call_behind) begin
                        direction <= call_ahead ? direction : ~direction;
                        state     <= MOVE;
                        cnt       <= '0;
                    end
                end
                MOVE: begin
                    if (cnt == MOVE_LAST) begin
                        cnt           <= '0;
                        current_floor <= step_floor;
                        // Stop on a latched call or one arriving on the very edge we reach the floor.
                        if (step_hit) begin
                            pending <= pend_req & ~step_bit;
                            arrived <= 1'b1;
                            state   <= DOOR;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DOOR: begin
                    if (req_here) begin
                        cnt <= '0;
                    end else if (cnt == DOOR_LAST) begin
                        cnt <= '0;
                        if (call_ahead) begin
                            state <= MOVE;
                        end else if (call_behind) begin
                            direction <= ~direction;
                            state     <= MOVE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
